// File: rtl/mem_dbus_access.sv
// mem_dbus_access: MEM-stage data-bus access FSM with store lane encoding and load extension (optional watchdog: DBUS_TIMEOUT_EN)
module mem_dbus_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_i,
    input  logic        advance,
    input  logic        flush,
    output logic        dbus_req,
    output logic        dbus_wr,
    output logic [1:0]  dbus_size,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_addr_ok,
    input  logic        dbus_data_ok,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] rdata_o,
    output logic        stallreq,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    logic [2:0]  state_q, state_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q, op_q;
    logic        is_load, is_store, mis, idle, in_req, issue, latch, timeout;
    logic [1:0]  size_c;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [3:0]  lop;
    logic [1:0]  llo;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [31:0] ld_c;
    // Decode the incoming op, detect misalignment and build the store lane encoding
    always_comb begin
        is_load  = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        is_store = op inside {4'd9, 4'd10, 4'd11};
        size_c   = (op inside {4'd3, 4'd4, 4'd10}) ? 2'd1 : (op inside {4'd5, 4'd11}) ? 2'd2 : 2'd0;
        mis      = (size_c == 2'd1 && addr[0]) || (size_c == 2'd2 && addr[1:0] != 2'b00);
        idle     = state_q == IDLE;
        in_req   = state_q == REQ;
        issue    = rst && idle && (is_load || is_store) && !mis && !flush;
        adel     = rst && idle && is_load && mis;
        ades     = rst && idle && is_store && mis;
        wstrb_c  = !is_store ? 4'b0000 :
                   size_c == 2'd0 ? 4'b0001 << addr[1:0] :
                   size_c == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_c  = !is_store ? 32'd0 :
                   size_c == 2'd0 ? {4{wdata_i[7:0]}} :
                   size_c == 2'd1 ? {2{wdata_i[15:0]}} : wdata_i;
    end
    // Bus outputs come straight from the decode on the issue cycle and from the captured copy while in REQ
    always_comb begin
        dbus_req   = issue || in_req;
        dbus_wr    = in_req ? wr_q    : issue && is_store;
        dbus_size  = in_req ? size_q  : issue ? size_c  : 2'd0;
        dbus_addr  = in_req ? addr_q  : issue ? addr    : 32'd0;
        dbus_wdata = in_req ? wdata_q : issue ? wdata_c : 32'd0;
        dbus_wstrb = in_req ? wstrb_q : issue ? wstrb_c : 4'b0000;
    end
    // Extract and extend the load lane; a zero-wait response uses the live op, later ones the captured op
    always_comb begin
        lop   = idle ? op : op_q;
        llo   = idle ? addr[1:0] : addr_q[1:0];
        lbyte = dbus_rdata[8*llo +: 8];
        lhalf = llo[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        ld_c  = lop == 4'd1 ? {{24{lbyte[7]}}, lbyte} :
                lop == 4'd2 ? {24'd0, lbyte} :
                lop == 4'd3 ? {{16{lhalf[15]}}, lhalf} :
                lop == 4'd4 ? {16'd0, lhalf} : dbus_rdata;
    end
    // Next-state logic; latch marks the cycle a load response is captured
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: if (issue) begin
                state_d = !dbus_addr_ok ? REQ : dbus_data_ok ? DONE : WAIT;
                latch   = dbus_addr_ok && dbus_data_ok;
            end
            REQ: if (dbus_addr_ok) begin
                state_d = flush ? (dbus_data_ok ? IDLE : DRAIN) : dbus_data_ok ? DONE : WAIT;
                latch   = !flush && dbus_data_ok;
            end else if (flush) state_d = IDLE;
            WAIT: if (dbus_data_ok) begin
                state_d = flush ? IDLE : DONE;
                latch   = !flush;
            end else if (flush || timeout) state_d = DRAIN;
            DONE:  if (advance || flush) state_d = IDLE;
            DRAIN: if (dbus_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign stallreq = issue || in_req || (state_q == WAIT && !timeout);
    assign bus_err  = timeout;
`ifdef DBUS_TIMEOUT_EN
    logic [7:0] cnt_q;
    // Watchdog counts WAIT cycles and restarts whenever the FSM is elsewhere
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 8'd0;
        else      cnt_q <= (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
    end
    assign timeout = state_q == WAIT && !dbus_data_ok && cnt_q == 8'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = TIMEOUT_CYCLES < 0;
`endif
    // State, captured request and load result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'b0000;
            op_q    <= 4'd0;
            rdata_o <= 32'd0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                wr_q    <= is_store;
                size_q  <= size_c;
                addr_q  <= addr;
                wdata_q <= wdata_c;
                wstrb_q <= wstrb_c;
                op_q    <= op;
            end
            if (latch && lop inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}) rdata_o <= ld_c;
        end
    end
endmodule

// File: tb/tb_mem_dbus_access.sv
// tb_mem_dbus_access: directed checks of the MEM-stage data-bus access block
module tb_mem_dbus_access;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] addr = 32'd0, wdata_i = 32'd0, dbus_rdata = 32'd0;
    logic        advance = 1'b0, flush = 1'b0, dbus_addr_ok = 1'b0, dbus_data_ok = 1'b0;
    logic        dbus_req, dbus_wr, stallreq, adel, ades, bus_err;
    logic [1:0]  dbus_size;
    logic [31:0] dbus_addr, dbus_wdata, rdata_o;
    logic [3:0]  dbus_wstrb;
    int          total = 0;
    int          bad = 0;

    mem_dbus_access dut (
        .clk(clk), .rst(rst), .op(op), .addr(addr), .wdata_i(wdata_i),
        .advance(advance), .flush(flush),
        .dbus_req(dbus_req), .dbus_wr(dbus_wr), .dbus_size(dbus_size),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
        .rdata_o(rdata_o), .stallreq(stallreq), .adel(adel), .ades(ades), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic zw_load(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
        op = o; addr = a; dbus_rdata = rd; dbus_addr_ok = 1'b1; dbus_data_ok = 1'b1;
        #1 chk({tag, "_stall"}, stallreq, 1);
        tick;
        op = 4'd0; dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0;
        #1 chk({tag, "_rdata"}, rdata_o, exp);
        chk({tag, "_done_stall"}, stallreq, 0);
        advance = 1'b1;
        tick;
        advance = 1'b0;
    endtask

    initial begin
        tick;
        chk("rst_req", dbus_req, 0);
        chk("rst_stall", stallreq, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", {adel, ades, bus_err}, 0);
        chk("rst_bus", {dbus_wr, dbus_size, dbus_wstrb}, 0);
        rst = 1'b1;
        tick;
        // LW, accepted at once, response two cycles later
        op = 4'd5; addr = 32'h1000; dbus_addr_ok = 1'b1;
        #1 chk("lw_req", dbus_req, 1);
        chk("lw_stall0", stallreq, 1);
        chk("lw_size", dbus_size, 2);
        chk("lw_wr_strb", {dbus_wr, dbus_wstrb}, 0);
        tick;
        dbus_addr_ok = 1'b0;
        #1 chk("lw_wait_req", dbus_req, 0);
        chk("lw_stall1", stallreq, 1);
        tick;
        dbus_data_ok = 1'b1; dbus_rdata = 32'hDEADBEEF;
        #1 chk("lw_stall2", stallreq, 1);
        tick;
        dbus_data_ok = 1'b0; dbus_rdata = 32'h0;
        #1 chk("lw_done_stall", stallreq, 0);
        chk("lw_rdata", rdata_o, 32'hDEADBEEF);
        chk("lw_done_noreq", dbus_req, 0);
        tick;
        chk("lw_hold", rdata_o, 32'hDEADBEEF);
        op = 4'd0; advance = 1'b1;
        tick;
        advance = 1'b0;
        #1 chk("lw_idle", {dbus_req, stallreq}, 0);
        // LB zero-wait, sign extended
        zw_load("lb", 4'd1, 32'h1003, 32'h80FFFFFF, 32'hFFFFFF80);
        // LBU through REQ with bus outputs held while the inputs change
        op = 4'd2; addr = 32'h1003; dbus_rdata = 32'h80FFFFFF;
        tick;
        op = 4'd0; addr = 32'h0;
        #1 chk("lbu_req", dbus_req, 1);
        chk("lbu_addr_held", dbus_addr, 32'h1003);
        chk("lbu_stall", stallreq, 1);
        dbus_addr_ok = 1'b1;
        tick;
        dbus_addr_ok = 1'b0; dbus_data_ok = 1'b1;
        tick;
        dbus_data_ok = 1'b0;
        #1 chk("lbu_rdata", rdata_o, 32'h00000080);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        // SH to upper half; store response leaves rdata_o alone
        op = 4'd10; addr = 32'h2002; wdata_i = 32'h0000ABCD; dbus_addr_ok = 1'b1; dbus_rdata = 32'h0;
        #1 chk("sh_strb", dbus_wstrb, 4'b1100);
        chk("sh_wdata", dbus_wdata, 32'hABCDABCD);
        chk("sh_size", dbus_size, 1);
        chk("sh_wr", dbus_wr, 1);
        tick;
        op = 4'd0; dbus_addr_ok = 1'b0; dbus_data_ok = 1'b1;
        tick;
        dbus_data_ok = 1'b0;
        #1 chk("sh_rdata_keep", rdata_o, 32'h00000080);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        // Flush in WAIT: DRAIN discards the response and blocks the next LW
        op = 4'd5; addr = 32'h4000; dbus_addr_ok = 1'b1;
        tick;
        dbus_addr_ok = 1'b0; flush = 1'b1;
        tick;
        flush = 1'b0; addr = 32'h5000;
        #1 chk("drain_req0", {dbus_req, stallreq}, 0);
        tick;
        chk("drain_req1", {dbus_req, stallreq}, 0);
        dbus_data_ok = 1'b1; dbus_rdata = 32'h11111111;
        #1 chk("drain_req2", dbus_req, 0);
        tick;
        dbus_data_ok = 1'b0;
        #1 chk("drain_discard", rdata_o, 32'h00000080);
        chk("post_drain_req", dbus_req, 1);
        chk("post_drain_addr", dbus_addr, 32'h5000);
        dbus_addr_ok = 1'b1; dbus_data_ok = 1'b1; dbus_rdata = 32'h22222222;
        tick;
        op = 4'd0; dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0;
        #1 chk("post_drain_rdata", rdata_o, 32'h22222222);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        // Flush in REQ drops back to IDLE
        op = 4'd5; addr = 32'h7000;
        tick;
        op = 4'd0; flush = 1'b1;
        tick;
        flush = 1'b0;
        #1 chk("req_flush_idle", {dbus_req, stallreq}, 0);
        // Store encodings, combinational only (op removed before the edge)
        op = 4'd9; addr = 32'h3001; wdata_i = 32'h12345678;
        #1 chk("sb_strb", dbus_wstrb, 4'b0010);
        chk("sb_wdata", dbus_wdata, 32'h78787878);
        chk("sb_size", dbus_size, 0);
        op = 4'd11; addr = 32'h3004; wdata_i = 32'hCAFEF00D;
        #1 chk("sw_strb", dbus_wstrb, 4'b1111);
        chk("sw_wdata", dbus_wdata, 32'hCAFEF00D);
        op = 4'd3; addr = 32'h3002;
        #1 chk("lh_enc", {dbus_wr, dbus_size, dbus_wstrb}, {1'b0, 2'd1, 4'b0000});
        op = 4'd7;
        #1 chk("bad_op_noreq", dbus_req, 0);
        // Misaligned accesses never reach the bus
        op = 4'd5; addr = 32'h1002;
        #1 chk("lw_mis_adel", {adel, ades}, 2'b10);
        chk("lw_mis_bus", {dbus_req, stallreq}, 0);
        tick;
        chk("lw_mis_hold", {dbus_req, stallreq, adel}, 3'b001);
        op = 4'd10; addr = 32'h2001;
        #1 chk("sh_mis_ades", {adel, ades, dbus_req}, 3'b010);
        op = 4'd0;
        #1 chk("mis_clear", {adel, ades}, 0);
        // Half and byte lane extraction
        zw_load("lh", 4'd3, 32'h1002, 32'h80017FFF, 32'hFFFF8001);
        zw_load("lhu", 4'd4, 32'h1000, 32'h1234F00D, 32'h0000F00D);
        zw_load("lb1", 4'd1, 32'h1001, 32'h00007F00, 32'h0000007F);
        // Reset mid-access abandons it; the late response is ignored
        op = 4'd5; addr = 32'h6000; dbus_addr_ok = 1'b1;
        tick;
        op = 4'd0; dbus_addr_ok = 1'b0; rst = 1'b0;
        #1 chk("midrst_stall", stallreq, 0);
        chk("midrst_rdata", rdata_o, 0);
        rst = 1'b1; dbus_data_ok = 1'b1; dbus_rdata = 32'h33333333;
        tick;
        dbus_data_ok = 1'b0;
        #1 chk("midrst_ignored", rdata_o, 0);
        chk("midrst_idle", {stallreq, bus_err}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_dbus_access.md
Name: mem_dbus_access

Overview:
- Memory-access stage logic directly downstream of the EX/MEM pipeline register.
- Consumes the registered load/store operation, effective address and store data.
- Drives the SRAM-like data bus (req / addr_ok / data_ok) with a small FSM and produces the aligned, extended load result for MEM/WB.
- Raises a pipeline stall request while an access is outstanding and reports address-error exceptions without touching the bus.

Parameters:
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature; counter is 8 bits).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- op  in  4  op from EX/MEM: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 9 SB, 10 SH, 11 SW; all other codes = none
- addr  in  32  effective address
- wdata_i  in  32  store source register value
- advance  in  1  MEM stage is allowed to move this cycle (no stall from later stages)
- flush  in  1  exception flush; discards the current access
- dbus_req  out  1  bus request
- dbus_wr  out  1  1 = store
- dbus_size  out  2  0 byte, 1 half, 2 word
- dbus_addr  out  32  byte address
- dbus_wdata  out  32  store data, replicated to all byte lanes
- dbus_wstrb  out  4  byte enables
- dbus_addr_ok  in  1  request accepted
- dbus_data_ok  in  1  response valid
- dbus_rdata  in  32  read data (full word)
- rdata_o  out  32  aligned and extended load result
- stallreq  out  1  stall request to the pipeline controller
- adel  out  1  load address error
- ades  out  1  store address error
- bus_err  out  1  timeout error (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rdata_o=0, dbus_req=0, dbus_wr=0, dbus_size=0, dbus_addr=0, dbus_wdata=0, dbus_wstrb=0, stallreq=0, adel=0, ades=0, bus_err=0.
  - Reset mid-access abandons the transaction; any later data_ok is ignored.
- Misalignment (combinational):
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - Misaligned load: adel=1. Misaligned store: ades=1.
  - No bus request is issued and stallreq=0.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - Valid, aligned op and flush=0: assert dbus_req combinationally in the same cycle; stallreq=1.
  - addr_ok=1 in that cycle -> WAIT; otherwise -> REQ.
- REQ:
  - dbus_req=1; all bus outputs held stable; stallreq=1.
  - addr_ok -> WAIT.
  - flush before addr_ok -> drop req, go to IDLE.
- WAIT:
  - dbus_req=0; stallreq=1.
  - data_ok -> latch the load result into rdata_o, go to DONE.
  - flush -> DRAIN.
  - addr_ok and data_ok in the same cycle as the request: pass through WAIT with zero wait cycles, i.e. go directly to DONE.
- DONE:
  - stallreq=0; rdata_o valid and held.
  - advance=1 -> IDLE. Hold in DONE while advance=0.
  - flush -> IDLE.
  - A new op only starts after returning to IDLE, so one access is issued per instruction.
- DRAIN:
  - stallreq=0, req=0.
  - data_ok -> IDLE; the response is discarded.
  - A new request is not issued until DRAIN exits.
- Store encoding:
  - SB: wstrb = 1 shifted left by addr[1:0]; wdata = {4{byte}}.
  - SH: wstrb = 0011 or 1100 by addr[1]; wdata = {2{half}}.
  - SW: wstrb = 1111.
  - dbus_wstrb=0 for loads.
- Load result:
  - Byte or half lane selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - rdata_o changes only on data_ok in WAIT.
- Bus outputs are registered when entering REQ and stable until addr_ok.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES sets bus_err=1 for one cycle, stallreq=0, and the FSM goes to DRAIN.
  - A late data_ok is absorbed in DRAIN.
- When undefined: no counter; bus_err is constant 0; WAIT waits indefinitely.

Test Plan:
- LW addr 0x1000, addr_ok same cycle, data_ok 2 cycles later with 0xDEADBEEF -> stallreq high 3 cycles, rdata_o=0xDEADBEEF, back to IDLE when advance=1.
- LB addr 0x1003, rdata 0x80FF_FFFF -> rdata_o=0xFFFFFF80; LBU on the same data -> 0x00000080.
- SH addr 0x2002, wdata_i=0x0000ABCD -> dbus_wstrb=1100, dbus_wdata=0xABCDABCD, dbus_size=1, dbus_wr=1.
- LW addr 0x1002 -> adel=1, dbus_req never asserted, stallreq=0.
- LW with flush asserted after addr_ok, data_ok 3 cycles later -> DRAIN, response discarded, rdata_o unchanged, next LW issued only after data_ok.
- With DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, data_ok never returned -> bus_err pulses 8 cycles after entering WAIT, stallreq drops.
